// File: rtl/sc_crash_sequencer.sv
// Frogger collision sequencer: per-tick obstacle row scan, hit evaluation, lives/hold/win/over control.
// Optional post-respawn immunity is built when SC_CRASHSEQ_INVULN_EN is defined.
module sc_crash_sequencer #(
  parameter int DATAWIDTH    = 8,
  parameter int LIVESWIDTH   = 2,
  parameter int LIVES_INIT   = 3,
  parameter int HOLD_TICKS   = 4,
  parameter int GOAL_ROW     = 7,
  parameter int INVULN_TICKS = 8
) (
  input  logic                  SC_CRASHSEQ_CLOCK_50,
  input  logic                  SC_CRASHSEQ_RESET_InLow,
  input  logic                  SC_CRASHSEQ_tick_InHigh,
  input  logic                  SC_CRASHSEQ_start_InLow,
  input  logic [2:0]            SC_CRASHSEQ_frogRow_InBUS,
  input  logic [DATAWIDTH-1:0]  SC_CRASHSEQ_frogCol_InBUS,
  output logic [2:0]            SC_CRASHSEQ_rowSel_OutBUS,
  input  logic [DATAWIDTH-1:0]  SC_CRASHSEQ_rowData_InBUS,
  output logic                  SC_CRASHSEQ_crash_OutHigh,
  output logic                  SC_CRASHSEQ_freeze_OutHigh,
  output logic                  SC_CRASHSEQ_frogReset_OutHigh,
  output logic [LIVESWIDTH-1:0] SC_CRASHSEQ_lives_OutBUS,
  output logic                  SC_CRASHSEQ_clear_OutHigh,
  output logic                  SC_CRASHSEQ_win_OutHigh,
  output logic                  SC_CRASHSEQ_gameOver_OutHigh,
  output logic                  SC_CRASHSEQ_invuln_OutHigh,
  output logic                  SC_CRASHSEQ_busy_OutHigh
);
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_EVAL, S_HOLD, S_WIN, S_OVER} state_t;

  localparam logic [LIVESWIDTH-1:0] LIVES_RST = LIVESWIDTH'(LIVES_INIT);
  localparam logic [3:0]            HOLD_LAST = 4'(HOLD_TICKS - 1);
  localparam logic [2:0]            GOAL      = 3'(GOAL_ROW);

  if (LIVES_INIT < 1 || LIVES_INIT > (1 << LIVESWIDTH) - 1) begin : g_bad_lives
    $error("LIVES_INIT out of range");
  end
  if (HOLD_TICKS < 1 || HOLD_TICKS > 15) begin : g_bad_hold
    $error("HOLD_TICKS out of range");
  end
  if (INVULN_TICKS < 1 || INVULN_TICKS > 15) begin : g_bad_invuln
    $error("INVULN_TICKS out of range");
  end

  state_t                r_state, w_state;
  logic [2:0]            r_rowSel, w_rowSel, r_prevSel, w_prevSel, r_row, w_row;
  logic                  r_dv, w_dv, r_hit, w_hit, r_nz, w_nz;
  logic                  r_clear, w_clear, r_crash, w_crash, r_frogReset, w_frogReset;
  logic [DATAWIDTH-1:0]  r_col, w_col;
  logic [LIVESWIDTH-1:0] r_lives, w_lives;
  logic [3:0]            r_holdCnt, w_holdCnt;
  logic                  w_rowHit, w_rowNz, w_immune;

`ifdef SC_CRASHSEQ_INVULN_EN
  localparam logic [3:0] INV_LOAD = 4'(INVULN_TICKS);
  logic       r_invuln, w_invuln, r_immune, w_immuneNxt;
  logic [3:0] r_invCnt, w_invCnt;
  assign w_immune                   = r_immune;
  assign SC_CRASHSEQ_invuln_OutHigh = r_invuln;
`else
  assign w_immune                   = 1'b0;
  assign SC_CRASHSEQ_invuln_OutHigh = 1'b0;
`endif

  // rowData on the bus belongs to the row addressed one cycle earlier (r_prevSel)
  assign w_rowHit = (r_prevSel == r_row) && (|(SC_CRASHSEQ_rowData_InBUS & r_col));
  assign w_rowNz  = |SC_CRASHSEQ_rowData_InBUS;

  always_comb begin
    w_state     = r_state;
    w_rowSel    = r_rowSel;
    w_prevSel   = r_prevSel;
    w_row       = r_row;
    w_col       = r_col;
    w_dv        = r_dv;
    w_hit       = r_hit;
    w_nz        = r_nz;
    w_clear     = r_clear;
    w_lives     = r_lives;
    w_holdCnt   = r_holdCnt;
    w_crash     = 1'b0;
    w_frogReset = 1'b0;
`ifdef SC_CRASHSEQ_INVULN_EN
    w_invuln    = r_invuln;
    w_invCnt    = r_invCnt;
    w_immuneNxt = r_immune;
`endif
    case (r_state)
      S_IDLE: if (SC_CRASHSEQ_tick_InHigh) begin
        w_state  = S_SCAN;
        w_row    = SC_CRASHSEQ_frogRow_InBUS;
        w_col    = SC_CRASHSEQ_frogCol_InBUS;
        w_hit    = 1'b0;
        w_nz     = 1'b0;
        w_dv     = 1'b0;
        w_rowSel = 3'd0;
`ifdef SC_CRASHSEQ_INVULN_EN
        // immunity is judged as it stood when the scan was launched
        w_immuneNxt = r_invuln;
        if (r_invuln) begin
          w_invCnt = r_invCnt - 4'd1;
          if (r_invCnt == 4'd1) w_invuln = 1'b0;
        end
`endif
      end
      S_SCAN: begin
        if (r_dv) begin
          w_hit = r_hit | w_rowHit;
          w_nz  = r_nz | w_rowNz;
        end
        w_prevSel = r_rowSel;
        w_dv      = 1'b1;
        if (r_rowSel == 3'd7) w_state = S_EVAL;
        else                  w_rowSel = r_rowSel + 3'd1;
      end
      S_EVAL: begin
        w_clear = ~(r_nz | w_rowNz);
        if ((r_hit | w_rowHit) & ~w_immune) begin
          w_crash = 1'b1;
          if (r_lives != '0) w_lives = r_lives - 1'b1;
          w_holdCnt = 4'd0;
          w_state   = (w_lives == '0) ? S_OVER : S_HOLD;
        end else if (r_row == GOAL) begin
          w_state = S_WIN;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_HOLD: if (SC_CRASHSEQ_tick_InHigh) begin
        if (r_holdCnt == HOLD_LAST) begin
          w_frogReset = 1'b1;
          w_state     = S_IDLE;
`ifdef SC_CRASHSEQ_INVULN_EN
          w_invCnt = INV_LOAD;
          w_invuln = 1'b1;
`endif
        end else begin
          w_holdCnt = r_holdCnt + 4'd1;
        end
      end
      S_WIN, S_OVER: if (!SC_CRASHSEQ_start_InLow) begin
        w_lives     = LIVES_RST;
        w_clear     = 1'b0;
        w_frogReset = 1'b1;
        w_state     = S_IDLE;
`ifdef SC_CRASHSEQ_INVULN_EN
        w_invuln = 1'b0;
        w_invCnt = 4'd0;
`endif
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge SC_CRASHSEQ_CLOCK_50 or negedge SC_CRASHSEQ_RESET_InLow) begin
    if (!SC_CRASHSEQ_RESET_InLow) begin
      r_state     <= S_IDLE;
      r_rowSel    <= 3'd0;
      r_prevSel   <= 3'd0;
      r_row       <= 3'd0;
      r_col       <= '0;
      r_dv        <= 1'b0;
      r_hit       <= 1'b0;
      r_nz        <= 1'b0;
      r_clear     <= 1'b0;
      r_lives     <= LIVES_RST;
      r_holdCnt   <= 4'd0;
      r_crash     <= 1'b0;
      r_frogReset <= 1'b0;
`ifdef SC_CRASHSEQ_INVULN_EN
      r_invuln    <= 1'b0;
      r_invCnt    <= 4'd0;
      r_immune    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_rowSel    <= w_rowSel;
      r_prevSel   <= w_prevSel;
      r_row       <= w_row;
      r_col       <= w_col;
      r_dv        <= w_dv;
      r_hit       <= w_hit;
      r_nz        <= w_nz;
      r_clear     <= w_clear;
      r_lives     <= w_lives;
      r_holdCnt   <= w_holdCnt;
      r_crash     <= w_crash;
      r_frogReset <= w_frogReset;
`ifdef SC_CRASHSEQ_INVULN_EN
      r_invuln    <= w_invuln;
      r_invCnt    <= w_invCnt;
      r_immune    <= w_immuneNxt;
`endif
    end
  end

  assign SC_CRASHSEQ_rowSel_OutBUS     = r_rowSel;
  assign SC_CRASHSEQ_crash_OutHigh     = r_crash;
  assign SC_CRASHSEQ_frogReset_OutHigh = r_frogReset;
  assign SC_CRASHSEQ_lives_OutBUS      = r_lives;
  assign SC_CRASHSEQ_clear_OutHigh     = r_clear;
  assign SC_CRASHSEQ_freeze_OutHigh    = (r_state == S_HOLD) || (r_state == S_WIN) || (r_state == S_OVER);
  assign SC_CRASHSEQ_win_OutHigh       = (r_state == S_WIN);
  assign SC_CRASHSEQ_gameOver_OutHigh  = (r_state == S_OVER);
  assign SC_CRASHSEQ_busy_OutHigh      = (r_state == S_SCAN) || (r_state == S_EVAL);
endmodule
